// File: rtl/forwarding_hazard_detect_unit_pkg.sv
// forwarding_hazard_detect_unit_pkg: shared types, constants and the operand match helper
// Contents:
//   REG_ADDR_W_DEF - default register-index width
//   CNT_W_DEF      - default stall-counter width
//   FWD_OP1_BIT    - enable bit for operand 1 (rs1)
//   FWD_OP2_BIT    - enable bit for operand 2 (rs2)
//   track_entry_t  - {valid, rd, reg_write, mem_read} of one in-flight instruction
//   src_match      - does a tracked producer feed a source operand of the ID instruction
package forwarding_hazard_detect_unit_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 16;
    localparam int FWD_OP1_BIT    = 0;
    localparam int FWD_OP2_BIT    = 1;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic                      reg_write;
        logic                      mem_read;
    } track_entry_t;

    // x0 is hard-wired zero, so a producer targeting it never forwards.
    function automatic logic src_match(
        input track_entry_t              e,
        input logic [REG_ADDR_W_DEF-1:0] rs,
        input logic                      used,
        input logic                      id_valid
    );
        return e.valid && e.reg_write && (e.rd != '0) && (e.rd == rs) && used && id_valid;
    endfunction

endpackage

// File: rtl/forwarding_hazard_detect_unit_if.sv
// forwarding_hazard_detect_unit_if: decode-side bundle between ID and the forwarding/hazard unit
// Signals:
//   id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
//   id_reg_write, id_mem_read - instruction currently in ID
//   flush                     - ID instruction squashed by a taken branch/jump
//   ex_busy                   - multi-cycle MUL/DIV in EX, pipeline frozen
//   mem_forward_en            - per-operand select of MEM_RD_DATA (bit0 op1, bit1 op2)
//   wb_forward_en             - per-operand select of WB_RD_DATA  (bit0 op1, bit1 op2)
//   hazard_stall              - load-use stall request
//   stall_count               - saturating number of load-use stalls taken
// Modports:
//   master - decode/pipeline control side
//   slave  - the forwarding/hazard unit
interface forwarding_hazard_detect_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic                  ex_busy;
    logic [1:0]            mem_forward_en;
    logic [1:0]            wb_forward_en;
    logic                  hazard_stall;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_read, flush, ex_busy,
        input  mem_forward_en, wb_forward_en, hazard_stall, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_read, flush, ex_busy,
        output mem_forward_en, wb_forward_en, hazard_stall, stall_count
    );

endinterface

// File: rtl/forwarding_hazard_detect_unit_hazard_track_entry.sv
// hazard_track_entry: one pipeline tracking register for an in-flight instruction
// Ports:
//   clk     - pipeline clock, rising edge
//   reset_n - asynchronous active-low reset, clears the entry
//   hold    - keep the current contents (frozen pipeline)
//   bubble  - load an invalid, all-zero entry instead of d
//   d       - entry to load on an advancing edge
//   q       - current entry
module hazard_track_entry
    import forwarding_hazard_detect_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         hold,
    input  logic         bubble,
    input  track_entry_t d,
    output track_entry_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (!hold)
            q <= bubble ? '0 : d;
    end

endmodule

// File: rtl/forwarding_hazard_detect_unit.sv
// forwarding_hazard_detect_unit: EX/MEM destination tracking, MEM/WB forward enables and load-use stall
// Ports:
//   clk     - pipeline clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - slave side of forwarding_hazard_detect_unit_if (ID instruction, flush,
//             ex_busy in; forward enables, hazard_stall, stall_count out)
module forwarding_hazard_detect_unit
    import forwarding_hazard_detect_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    forwarding_hazard_detect_unit_if.slave bus
);

    track_entry_t     id_entry;
    track_entry_t     ex_t;
    track_entry_t     mem_t;
    logic             ex_match1;
    logic             ex_match2;
    logic             mem_match1;
    logic             mem_match2;
    logic             hazard;
    logic             bubble;
    logic [1:0]       mem_fwd;
    logic [1:0]       wb_fwd;
    logic [CNT_W-1:0] stall_cnt;

    assign id_entry = '{
        valid:     bus.id_valid,
        rd:        bus.id_rd,
        reg_write: bus.id_reg_write,
        mem_read:  bus.id_mem_read
    };

    assign ex_match1  = src_match(ex_t,  bus.id_rs1, bus.id_rs1_used, bus.id_valid);
    assign ex_match2  = src_match(ex_t,  bus.id_rs2, bus.id_rs2_used, bus.id_valid);
    assign mem_match1 = src_match(mem_t, bus.id_rs1, bus.id_rs1_used, bus.id_valid);
    assign mem_match2 = src_match(mem_t, bus.id_rs2, bus.id_rs2_used, bus.id_valid);

    // A load in EX cannot forward yet: its data only exists after MEM.
    assign hazard = ex_t.mem_read && (ex_match1 || ex_match2);

    // Nothing real enters EX when stalled, squashed or when ID is empty.
    assign bubble = hazard || bus.flush || !bus.id_valid;

    hazard_track_entry u_ex_entry (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (bus.ex_busy),
        .bubble  (bubble),
        .d       (id_entry),
        .q       (ex_t)
    );

    // MEM always takes whatever EX held, bubbles included.
    hazard_track_entry u_mem_entry (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (bus.ex_busy),
        .bubble  (1'b0),
        .d       (ex_t),
        .q       (mem_t)
    );

    // Enables are registered so they line up with the instruction's EX cycle.
    // MEM and WB bits are independent; the consumer prefers MEM (newest value).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_fwd   <= '0;
            wb_fwd    <= '0;
            stall_cnt <= '0;
        end else if (!bus.ex_busy) begin
            mem_fwd[FWD_OP1_BIT] <= !bubble && ex_match1;
            mem_fwd[FWD_OP2_BIT] <= !bubble && ex_match2;
            wb_fwd[FWD_OP1_BIT]  <= !bubble && mem_match1;
            wb_fwd[FWD_OP2_BIT]  <= !bubble && mem_match2;
            // A flush discards the stalled instruction, so that stall is not counted.
            if (hazard && !bus.flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.mem_forward_en = mem_fwd;
    assign bus.wb_forward_en  = wb_fwd;
    assign bus.hazard_stall   = hazard;
    assign bus.stall_count    = stall_cnt;

endmodule

// File: tb/tb_forwarding_hazard_detect_unit.sv
// tb_forwarding_hazard_detect_unit: directed self-checking bench for forwarding_hazard_detect_unit
module tb_forwarding_hazard_detect_unit;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    forwarding_hazard_detect_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();

    forwarding_hazard_detect_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs1_used  = u1;
        bus.id_rs2       = rs2;
        bus.id_rs2_used  = u2;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] mem, input logic [1:0] wb);
        chk({tag, "_mem"}, 32'(bus.mem_forward_en), 32'(mem));
        chk({tag, "_wb"},  32'(bus.wb_forward_en),  32'(wb));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.flush   = 1'b0;
        bus.ex_busy = 1'b0;
        nop();
        #1;
        chk_fwd("reset", 2'b00, 2'b00);
        chk("reset_stall", 32'(bus.hazard_stall), 32'd0);
        chk("reset_cnt",   32'(bus.stall_count),  32'd0);
        #12 reset_n = 1'b1;
        tick();

        // back-to-back: add x5 ; sub x8, x5, x6
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        #1 chk("b2b_stall", 32'(bus.hazard_stall), 32'd0);
        tick();
        chk_fwd("b2b", 2'b01, 2'b00);

        // distance 2: add x7 ; nop ; rs2 = x7
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        chk_fwd("d2_bubble", 2'b00, 2'b00);
        drive(1'b1, 5'd9, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        chk_fwd("d2", 2'b00, 2'b10);

        // load-use: lw x3 ; add x11, x3, x3
        nop();
        tick();
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
        #1;
        chk("lu_stall_on", 32'(bus.hazard_stall), 32'd1);
        chk("lu_cnt0",     32'(bus.stall_count),  32'd0);
        tick();
        chk("lu_stall_off", 32'(bus.hazard_stall), 32'd0);
        chk("lu_cnt1",      32'(bus.stall_count),  32'd1);
        chk_fwd("lu_bubble", 2'b00, 2'b00);
        tick();
        chk_fwd("lu_retry", 2'b00, 2'b11);
        chk("lu_cnt_hold", 32'(bus.stall_count), 32'd1);

        // x0 never matches
        nop();
        tick();
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);
        #1 chk("x0_stall", 32'(bus.hazard_stall), 32'd0);
        tick();
        chk_fwd("x0", 2'b00, 2'b00);

        // double match: addi x4 ; addi x4 ; reader of x4
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        tick();
        drive(1'b1, 5'd4, 1'b1, 5'd13, 1'b1, 5'd14, 1'b1, 1'b0);
        tick();
        chk_fwd("dbl", 2'b01, 2'b01);

        // ex_busy freezes everything for 3 cycles with a dependency pending
        nop();
        tick();
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd15, 1'b1, 1'b0);
        tick();
        chk_fwd("busy_pre", 2'b01, 2'b00);
        drive(1'b1, 5'd15, 1'b1, 5'd5, 1'b1, 5'd16, 1'b1, 1'b0);
        bus.ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fwd($sformatf("busy_hold%0d", i), 2'b01, 2'b00);
        end
        bus.ex_busy = 1'b0;
        tick();
        chk_fwd("busy_resume", 2'b01, 2'b10);

        // busy with a load-use pending, then flush coincident with the stall
        nop();
        tick();
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0);
        bus.ex_busy = 1'b1;
        #1 chk("busy_lu_stall", 32'(bus.hazard_stall), 32'd1);
        tick();
        tick();
        chk("busy_lu_stall2", 32'(bus.hazard_stall), 32'd1);
        chk("busy_lu_cnt",    32'(bus.stall_count),  32'd1);
        bus.ex_busy = 1'b0;
        bus.flush   = 1'b1;
        #1 chk("flush_stall", 32'(bus.hazard_stall), 32'd1);
        tick();
        bus.flush = 1'b0;
        nop();
        #1;
        chk("flush_cnt",      32'(bus.stall_count),  32'd1);
        chk("flush_stall_off", 32'(bus.hazard_stall), 32'd0);
        chk_fwd("flush", 2'b00, 2'b00);

        // four more load-use stalls: count reaches 5, WB enables end at 2'b11
        for (int i = 0; i < 4; i++) begin
            nop();
            tick();
            tick();
            drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
            #1 chk($sformatf("rep_stall%0d", i), 32'(bus.hazard_stall), 32'd1);
            tick();
            tick();
        end
        chk("pre_rst_cnt", 32'(bus.stall_count), 32'd5);
        chk_fwd("pre_rst", 2'b00, 2'b11);

        // asynchronous reset mid-cycle
        #2 reset_n = 1'b0;
        #1;
        chk_fwd("async_rst", 2'b00, 2'b00);
        chk("async_rst_cnt",   32'(bus.stall_count),  32'd0);
        chk("async_rst_stall", 32'(bus.hazard_stall), 32'd0);
        nop();
        #2 reset_n = 1'b1;
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        chk_fwd("post_rst_b2b", 2'b01, 2'b00);
        chk("post_rst_cnt", 32'(bus.stall_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
